// File: rtl/mcu_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, opcode values,
// datapath select encodings, and the per-state Moore control word.
package mcu_pkg;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, WB_ALU, ADDR,
      MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_LW   = 4'b1000;
   localparam logic [3:0] OP_SW   = 4'b1010;
   localparam logic [3:0] OP_BEQ  = 4'b1110;
   localparam logic [3:0] OP_J    = 4'b1111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   localparam logic [1:0] SRCB_RT  = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic rtype;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic illegal;
   } op_class_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       illegal;
   } ctrl_t;

   // Moore control word for each state; the FETCH handshake strobes are added outside.
   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c = '0;
      unique case (s)
         FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_b = SRCB_ONE;
            c.alu_op    = ALU_ADD;
            c.pc_src    = PC_ALU;
         end
         DECODE: begin
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RT;
            c.alu_op    = ALU_FUNC;
         end
         WB_ALU: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         MEM_RD: begin
            c.mem_req = 1'b1;
            c.i_or_d  = 1'b1;
         end
         WB_MEM: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         MEM_WR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.i_or_d  = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_RT;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = PC_ALUOUT;
         end
         JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = PC_JUMP;
         end
         TRAP: c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode to one-hot instruction class; shared with the
// single-cycle decoder so both cores agree on what is legal.
module op_classify
   import mcu_pkg::*;
(
   input  logic [3:0] op_i,
   output op_class_t  class_o
);

   always_comb begin
      class_o = '0;
      unique case (op_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: class_o.rtype  = 1'b1;
         OP_LW:                                 class_o.load   = 1'b1;
         OP_SW:                                 class_o.store  = 1'b1;
         OP_BEQ:                                class_o.branch = 1'b1;
         OP_J:                                  class_o.jump   = 1'b1;
         default:                               class_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer with a memory handshake and a retired-instruction
// counter. Control outputs are registered from the next state.
module multicycle_control
   import mcu_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   ctrl_t            ctrl_q;
   logic [CNT_W-1:0] retired_q;
   op_class_t        opClass;
   logic             retire;
   logic             fetchAccept;

   op_classify u_classify (
      .op_i    (op),
      .class_o (opClass)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   state_d = FETCH;
         FETCH:  if (mem_ready) state_d = DECODE;
         DECODE: begin
            if (opClass.rtype)                      state_d = EXEC;
            else if (opClass.load || opClass.store) state_d = ADDR;
            else if (opClass.branch)                state_d = BRANCH;
            else if (opClass.jump)                  state_d = JUMP;
            else                                    state_d = TRAP;
         end
         EXEC:   state_d = WB_ALU;
         WB_ALU: state_d = FETCH;
         // op must still be a memory op here; anything else is treated as illegal.
         ADDR: begin
            if (opClass.load)       state_d = MEM_RD;
            else if (opClass.store) state_d = MEM_WR;
            else                    state_d = TRAP;
         end
         MEM_RD: if (mem_ready) state_d = WB_MEM;
         WB_MEM: state_d = FETCH;
         MEM_WR: if (mem_ready) state_d = FETCH;
         BRANCH: state_d = FETCH;
         JUMP:   state_d = FETCH;
         TRAP:   state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   // Every way into FETCH except the startup one completes an instruction.
   assign retire = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_for(state_d);
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   // The IR/PC load strobes are the only outputs that follow mem_ready directly.
   assign fetchAccept   = (state_q == FETCH) && mem_ready;

   assign mem_req       = ctrl_q.mem_req;
   assign mem_we        = ctrl_q.mem_we;
   assign i_or_d        = ctrl_q.i_or_d;
   assign ir_write      = fetchAccept;
   assign pc_write      = ctrl_q.pc_write | fetchAccept;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign pc_src        = ctrl_q.pc_src;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign reg_write     = ctrl_q.reg_write;
   assign illegal       = ctrl_q.illegal;
   assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: walks instructions cycle by cycle
// against an instruction-level model of control words, wait states and retire count.
module tb_multicycle_control;

   localparam int TB_CNT_W = 4;

   // Control word layout: mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
   // pc_src[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_dst, mem_to_reg, reg_write, illegal
   localparam logic [16:0] V_ZERO       = 17'h0;
   localparam logic [16:0] V_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_FETCH_GO   = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_WB_ALU     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0};
   localparam logic [16:0] V_ADDR       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_MEM_RD     = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_WB_MEM     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0};
   localparam logic [16:0] V_MEM_WR     = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_BRANCH     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_JUMP       = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_TRAP       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};

   localparam int C_RTYPE = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_JUMP = 4, C_ILLEGAL = 5;

   logic                clk;
   logic                rst_n;
   logic [3:0]          op;
   logic                memReady;
   logic                mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
   logic [1:0]          pc_src, alu_src_b, alu_op;
   logic                alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
   logic [TB_CNT_W-1:0] retired;
   logic [16:0]         obsCtl;

   int compared   = 0;
   int mismatched = 0;
   int expRetired = 0;

   logic [3:0] legalOps   [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                  4'b1000, 4'b1010, 4'b1110, 4'b1111};
   logic [3:0] illegalOps [7] = '{4'b0011, 4'b0100, 4'b0101, 4'b1001,
                                  4'b1011, 4'b1100, 4'b1101};

   multicycle_control #(.CNT_W(TB_CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .mem_ready     (memReady),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .illegal       (illegal),
      .retired       (retired)
   );

   assign obsCtl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                    alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};

   always #5 clk = ~clk;

   // Opcode classes written straight from the instruction-set table.
   function automatic int classOf(input logic [3:0] o);
      case (o)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: return C_RTYPE;
         4'b1000: return C_LOAD;
         4'b1010: return C_STORE;
         4'b1110: return C_BRANCH;
         4'b1111: return C_JUMP;
         default: return C_ILLEGAL;
      endcase
   endfunction

   function automatic logic randBit();
      return 1'($urandom_range(1));
   endfunction

   function automatic logic [3:0] randOp();
      return 4'($urandom_range(15));
   endfunction

   task automatic applyStimulus(input logic ready, input logic [3:0] opv);
      memReady = ready;
      op       = opv;
   endtask

   task automatic checkOutput(input string tag, input logic [16:0] expCtl);
      compared++;
      assert (obsCtl === expCtl) else begin
         mismatched++;
         $error("[TB] FAIL %s ctl observed=%h expected=%h", tag, obsCtl, expCtl);
      end
      compared++;
      assert (retired === TB_CNT_W'(expRetired)) else begin
         mismatched++;
         $error("[TB] FAIL %s retired observed=%0d expected=%0d", tag, retired, TB_CNT_W'(expRetired));
      end
   endtask

   // One clock cycle: drive inputs just after the edge, check mid-cycle, advance.
   task automatic stepCycle(input string tag, input logic ready, input logic [3:0] opv,
                            input logic [16:0] expCtl);
      applyStimulus(ready, opv);
      #1;
      checkOutput(tag, expCtl);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n      = 1'b0;
      expRetired = 0;
      #1;
      checkOutput("reset_now", V_ZERO);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_held", V_ZERO);
      rst_n = 1'b1;
      stepCycle("idle", randBit(), randOp(), V_ZERO);
   endtask

   task automatic fetchPhase(input int fw);
      for (int i = 0; i < fw; i++) stepCycle("fetch_wait", 1'b0, randOp(), V_FETCH_WAIT);
      stepCycle("fetch", 1'b1, randOp(), V_FETCH_GO);
   endtask

   // Full instruction from FETCH back to FETCH (or into TRAP for illegal opcodes).
   task automatic runInstr(input logic [3:0] opv, input int fw, input int mw);
      fetchPhase(fw);
      stepCycle("decode", randBit(), opv, V_DECODE);
      case (classOf(opv))
         C_RTYPE: begin
            stepCycle("exec", randBit(), randOp(), V_EXEC);
            stepCycle("wb_alu", randBit(), randOp(), V_WB_ALU);
            expRetired++;
         end
         C_LOAD: begin
            stepCycle("addr_ld", randBit(), opv, V_ADDR);
            for (int i = 0; i < mw; i++) stepCycle("mem_rd_wait", 1'b0, randOp(), V_MEM_RD);
            stepCycle("mem_rd", 1'b1, randOp(), V_MEM_RD);
            stepCycle("wb_mem", randBit(), randOp(), V_WB_MEM);
            expRetired++;
         end
         C_STORE: begin
            stepCycle("addr_st", randBit(), opv, V_ADDR);
            for (int i = 0; i < mw; i++) stepCycle("mem_wr_wait", 1'b0, randOp(), V_MEM_WR);
            stepCycle("mem_wr", 1'b1, randOp(), V_MEM_WR);
            expRetired++;
         end
         C_BRANCH: begin
            stepCycle("branch", randBit(), randOp(), V_BRANCH);
            expRetired++;
         end
         C_JUMP: begin
            stepCycle("jump", randBit(), randOp(), V_JUMP);
            expRetired++;
         end
         default: begin
            for (int i = 0; i < 12; i++) stepCycle("trap", randBit(), randOp(), V_TRAP);
         end
      endcase
   endtask

   initial begin
      clk      = 1'b0;
      rst_n    = 1'b0;
      memReady = 1'b0;
      op       = 4'b0000;
      #2;

      $display("[TB] reset and first R-type");
      doReset();
      runInstr(4'b0000, 0, 0);

      $display("[TB] directed load/store/branch/jump");
      runInstr(4'b1000, 1, 2);
      runInstr(4'b1010, 0, 1);
      runInstr(4'b1110, 0, 0);
      runInstr(4'b1111, 2, 0);

      $display("[TB] random legal instruction stream");
      for (int n = 0; n < 24; n++)
         runInstr(legalOps[$urandom_range(8)], $urandom_range(2), $urandom_range(3));

      $display("[TB] reset during a load access");
      fetchPhase(0);
      stepCycle("decode", randBit(), 4'b1000, V_DECODE);
      stepCycle("addr_ld", randBit(), 4'b1000, V_ADDR);
      stepCycle("mem_rd_wait", 1'b0, randOp(), V_MEM_RD);
      doReset();
      runInstr(4'b0111, 0, 0);
      runInstr(4'b1010, 1, 0);

      $display("[TB] illegal opcodes trap until reset");
      runInstr(4'b0100, 0, 0);
      doReset();
      runInstr(illegalOps[$urandom_range(6)], $urandom_range(2), 0);
      doReset();
      runInstr(4'b0110, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 4-bit-opcode MIPS-style core. Replaces the single-cycle decoder with a Moore FSM plus a memory handshake, so one shared memory port and one ALU serve fetch, address calculation and data access. Sits between the instruction register (`op`) and the datapath mux, enable and ALU selects. Also counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  4  opcode from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current `mem_req` this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe, qualifies `mem_req`.
- `i_or_d`  out  1  memory address source: 0 = PC, 1 = ALU output register.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero.
- `pc_src`  out  2  PC source: 00 = ALU, 01 = ALU output register (branch target), 10 = jump target.
- `alu_src_a`  out  1  ALU A: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B: 00 = rt, 01 = constant 1, 10 = sign-extended immediate.
- `alu_op`  out  2  ALU op: 00 = add, 01 = sub (compare), 10 = function from `op`.
- `reg_dst`  out  1  destination register: 1 = rd, 0 = rt.
- `mem_to_reg`  out  1  write-back source: 1 = memory data.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  sticky: an undefined opcode was decoded.
- `retired`  out  CNT_W  instructions completed, wraps modulo 2^CNT_W.

## Operation
- Opcode classes:
  - R-type: 0000, 0001, 0010, 0110, 0111.
  - LOAD: 1000.
  - STORE: 1010.
  - BRANCH: 1110.
  - JUMP: 1111.
  - Illegal: 0011, 0100, 0101, 1001, 1011, 1100, 1101.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH.
- FETCH: `mem_req=1`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=00`, `pc_src=00`.
  - `ir_write` and `pc_write` are asserted only in the cycle `mem_ready=1`. This is the only Mealy output.
  - Holds while `mem_ready=0`. Goes to DECODE when `mem_ready=1`.
- DECODE: `alu_src_a=0`, `alu_src_b=10`, `alu_op=00` (precomputes the branch target). Dispatches on class:
  - R-type → EXEC.
  - LOAD or STORE → ADDR.
  - BRANCH → BRANCH.
  - JUMP → JUMP.
  - Illegal → TRAP.
- EXEC: `alu_src_a=1`, `alu_src_b=00`, `alu_op=10`. Goes to WB_ALU.
- WB_ALU: `reg_dst=1`, `reg_write=1`. Goes to FETCH and retires.
- ADDR: `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`. Goes to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: `mem_req=1`, `i_or_d=1`. Holds until `mem_ready`, then goes to WB_MEM.
- WB_MEM: `reg_dst=0`, `mem_to_reg=1`, `reg_write=1`. Goes to FETCH and retires.
- MEM_WR: `mem_req=1`, `mem_we=1`, `i_or_d=1`. Holds until `mem_ready`, then goes to FETCH and retires.
- BRANCH: `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_write_cond=1`, `pc_src=01`. Goes to FETCH and retires.
- JUMP: `pc_write=1`, `pc_src=10`. Goes to FETCH and retires.
- TRAP: `illegal=1`. Terminal; only reset leaves it. Does not retire.
- `retired` increments by 1 on each retiring transition and wraps from all-ones to 0.

## Timing
- `rst_n` low, at any time including mid-access: state becomes IDLE, `retired` becomes 0, `illegal` becomes 0. All outputs are 0 while reset is held.
- First `mem_req` is asserted in the second clock after reset release (IDLE lasts one cycle).
- Cycles per instruction with zero-wait memory:
  - R-type 4, LOAD 5, STORE 4, BRANCH 3, JUMP 3.
  - Each wait cycle adds 1.
- `mem_req` stays high and `i_or_d`/`mem_we` stay stable until the cycle `mem_ready=1` is sampled. `mem_ready` is ignored when `mem_req=0`.
- `op` is sampled only in DECODE and ADDR.
- `retired` updates on the clock edge that enters FETCH.

## Structure
- Package `mcu_pkg`:
  - state enum: IDLE, FETCH, DECODE, EXEC, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP;
  - opcode localparams;
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `op_classify`: combinational `op` → one-hot class (rtype, load, store, branch, jump, illegal). Shared with the existing single-cycle decoder.
- Top block contains the state register, next-state logic, output decode and the retire counter.

## Test plan
- Reset release, `op=0000`, `mem_ready=1` → states IDLE, FETCH, DECODE, EXEC, WB_ALU; `reg_write=1`, `reg_dst=1` in cycle 5; `retired=1`.
- LOAD `op=1000`, `mem_ready` low for 2 cycles in MEM_RD → `mem_req`/`i_or_d` held high for 3 cycles; WB_MEM asserts `mem_to_reg=1`, `reg_dst=0`.
- STORE `op=1010` → MEM_WR asserts `mem_we=1`, `reg_write=0`; next state FETCH.
- BRANCH `1110` then JUMP `1111` → `pc_write_cond=1`, `pc_src=01`, then `pc_write=1`, `pc_src=10`; `retired` increases by 2.
- `op=0100` → TRAP; `illegal=1` sticky; `mem_req` stays 0 for 10+ cycles; `rst_n` pulse clears it.
- `rst_n` asserted mid MEM_RD → outputs 0 immediately; restart from IDLE. With `CNT_W=4`, 16 retires wrap `retired` to 0.
